// File: rtl/m3_deadtime_guard.sv
// Dead-time insertion and shoot-through guard for a three-phase bridge.
// One OFF/HIGH/LOW/DEAD FSM per phase; a sticky fault forces every phase down to OFF.
module m3_deadtime_guard #(
   parameter int DEAD_CYC = 50,
   parameter int CNT_W    = 8
) (
   input  logic       clk50mhzI,
   input  logic       nResetI,
   input  logic       enableI,
   input  logic       aHreqI,
   input  logic       bHreqI,
   input  logic       cHreqI,
   input  logic       aLreqI,
   input  logic       bLreqI,
   input  logic       cLreqI,
   input  logic       faultClrI,
   output logic       aHPo,
   output logic       bHPo,
   output logic       cHPo,
   output logic       aLNo,
   output logic       bLNo,
   output logic       cLNo,
   output logic [2:0] deadO,
   output logic       faultO
);

   typedef enum logic [1:0] {ST_OFF, ST_HIGH, ST_LOW, ST_DEAD} state_t;

   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [2:0] hreq;
   logic [2:0] lreq;
   logic [2:0] conflict;
   logic [2:0] hp;
   logic [2:0] ln;
   logic [2:0] dead;
   logic       block;
   logic       fault_reg;
   logic       fault_next;

   assign hreq     = {cHreqI, bHreqI, aHreqI};
   assign lreq     = {cLreqI, bLreqI, aLreqI};
   assign conflict = hreq & lreq;

   // A conflict on any phase blocks all phases in the same cycle it is seen,
   // so on-gates drop on the very edge that raises the fault.
   assign block = !enableI || fault_reg || (|conflict);

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_phase
         state_t           state_reg;
         state_t           state_next;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             want_h;
         logic             want_l;

         assign want_h = !block && hreq[gi] && !lreq[gi];
         assign want_l = !block && lreq[gi] && !hreq[gi];

         always_ff @(posedge clk50mhzI) begin
            if (!nResetI) begin
               state_reg <= ST_OFF;
               cnt_reg   <= '0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            case (state_reg)
               ST_OFF: begin
                  if (want_h)      state_next = ST_HIGH;
                  else if (want_l) state_next = ST_LOW;
               end
               ST_HIGH: begin
                  if (!want_h) begin
                     state_next = ST_DEAD;
                     cnt_next   = DEAD_LOAD;
                  end
               end
               ST_LOW: begin
                  if (!want_l) begin
                     state_next = ST_DEAD;
                     cnt_next   = DEAD_LOAD;
                  end
               end
               default: begin
                  // Dead time always completes; the exit side is chosen only at cnt=0.
                  if (cnt_reg != '0) begin
                     cnt_next = cnt_reg - CNT_ONE;
                  end else if (want_h) begin
                     state_next = ST_HIGH;
                  end else if (want_l) begin
                     state_next = ST_LOW;
                  end else begin
                     state_next = ST_OFF;
                  end
               end
            endcase
         end

         assign hp[gi]   = (state_reg == ST_HIGH);
         assign ln[gi]   = (state_reg == ST_LOW);
         assign dead[gi] = (state_reg == ST_DEAD);
      end
   endgenerate

   // Set has priority over a simultaneous clear.
   always_comb begin
      fault_next = fault_reg;
      if (|conflict)      fault_next = 1'b1;
      else if (faultClrI) fault_next = 1'b0;
   end

   always_ff @(posedge clk50mhzI) begin
      if (!nResetI) fault_reg <= 1'b0;
      else          fault_reg <= fault_next;
   end

   assign aHPo   = hp[0];
   assign bHPo   = hp[1];
   assign cHPo   = hp[2];
   assign aLNo   = ln[0];
   assign bLNo   = ln[1];
   assign cLNo   = ln[2];
   assign deadO  = dead;
   assign faultO = fault_reg;

endmodule

// File: tb/tb_m3_deadtime_guard.sv
// Scoreboard bench for m3_deadtime_guard: directed sequences then random requests,
// expected outputs from a timestamp-based model of the dead-time rules.
module tb_m3_deadtime_guard;

   localparam int DC = 4;

   logic       clk;
   logic       rstn;
   logic       en;
   logic [2:0] h;
   logic [2:0] l;
   logic       clr;
   logic       a_hp, b_hp, c_hp, a_ln, b_ln, c_ln;
   logic [2:0] dead;
   logic       fault;

   m3_deadtime_guard #(.DEAD_CYC(DC), .CNT_W(8)) dut (
      .clk50mhzI(clk),
      .nResetI  (rstn),
      .enableI  (en),
      .aHreqI   (h[0]),
      .bHreqI   (h[1]),
      .cHreqI   (h[2]),
      .aLreqI   (l[0]),
      .bLreqI   (l[1]),
      .cLreqI   (l[2]),
      .faultClrI(clr),
      .aHPo     (a_hp),
      .bHPo     (b_hp),
      .cHPo     (c_hp),
      .aLNo     (a_ln),
      .bLNo     (b_ln),
      .cLNo     (c_ln),
      .deadO    (dead),
      .faultO   (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected word: {fault, dead[2:0], ln[2:0], hp[2:0]}
   logic [9:0] exp_q[$];
   int         compared = 0;
   int         mismatched = 0;
   bit         stim_done = 0;

   // Model: each phase is on one side (1=H, 2=L) or off; leaving a side stamps
   // the edge index from which a new request may be honoured again.
   int  m_side[3];
   int  m_free[3];
   bit  m_fault;
   int  edge_n;

   task automatic step(input logic [2:0] hh, input logic [2:0] ll,
                       input logic ee, input logic cc, input logic rr);
      logic [9:0] e;
      bit         blk;
      int         r;
      @(negedge clk);
      h = hh; l = ll; en = ee; clr = cc; rstn = rr;
      if (!rr) begin
         for (int i = 0; i < 3; i++) begin
            m_side[i] = 0;
            m_free[i] = 0;
         end
         m_fault = 0;
      end else begin
         blk = !ee || m_fault || ((hh & ll) != 3'b000);
         for (int i = 0; i < 3; i++) begin
            if (blk)                 r = 0;
            else if (hh[i] && !ll[i]) r = 1;
            else if (ll[i] && !hh[i]) r = 2;
            else                      r = 0;
            if (m_side[i] != 0) begin
               if (r != m_side[i]) begin
                  m_side[i] = 0;
                  m_free[i] = edge_n + DC;
               end
            end else if (edge_n >= m_free[i]) begin
               m_side[i] = r;
            end
         end
         if ((hh & ll) != 3'b000) m_fault = 1;
         else if (cc)            m_fault = 0;
      end
      for (int i = 0; i < 3; i++) begin
         e[i]     = (m_side[i] == 1);
         e[3 + i] = (m_side[i] == 2);
         e[6 + i] = (m_side[i] == 0) && (edge_n < m_free[i]);
      end
      e[9] = m_fault;
      exp_q.push_back(e);
      edge_n++;
   endtask

   task automatic hold(input logic [2:0] hh, input logic [2:0] ll,
                       input logic ee, input int n);
      for (int k = 0; k < n; k++) step(hh, ll, ee, 1'b0, 1'b1);
   endtask

   // Monitor: every edge presents one output word.
   initial begin : monitor
      logic [9:0] act;
      logic [9:0] want;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            act  = {fault, dead, c_ln, b_ln, a_ln, c_hp, b_hp, a_hp};
            compared++;
            if (act !== want) begin
               mismatched++;
               $display("FAIL outputs edge: got f=%b dead=%b ln=%b hp=%b, expected f=%b dead=%b ln=%b hp=%b",
                        act[9], act[8:6], act[5:3], act[2:0],
                        want[9], want[8:6], want[5:3], want[2:0]);
            end
            compared++;
            if ((act[5:3] & act[2:0]) != 3'b000) begin
               mismatched++;
               $display("FAIL shoot_through: hp=%b ln=%b, required no overlap", act[2:0], act[5:3]);
            end
         end
      end
   end

   initial begin : stimulus
      logic [2:0] rh, rl;
      logic       ren;
      int         wait_cnt;
      h = 3'b000; l = 3'b000; en = 1'b1; clr = 1'b0; rstn = 1'b0;
      m_fault = 0; edge_n = 0;
      for (int i = 0; i < 3; i++) begin
         m_side[i] = 0;
         m_free[i] = 0;
      end

      step(3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      step(3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      hold(3'b001, 3'b000, 1'b1, 3);            // OFF -> HIGH, 1-cycle latency
      hold(3'b000, 3'b001, 1'b1, 7);            // H -> L through 4 dead cycles
      hold(3'b001, 3'b000, 1'b1, 7);
      hold(3'b000, 3'b000, 1'b1, 1);            // one-cycle drop, dead still runs
      hold(3'b001, 3'b000, 1'b1, 7);
      hold(3'b001, 3'b100, 1'b1, 6);            // a and c on
      hold(3'b011, 3'b110, 1'b1, 2);            // conflict on b
      step(3'b011, 3'b110, 1'b1, 1'b1, 1'b1);   // clear loses to set
      hold(3'b001, 3'b100, 1'b1, 6);
      step(3'b001, 3'b100, 1'b1, 1'b1, 1'b1);   // clear with conflict gone
      hold(3'b001, 3'b100, 1'b1, 7);
      hold(3'b001, 3'b100, 1'b0, 2);            // enable low mid-HIGH
      hold(3'b001, 3'b100, 1'b1, 7);
      hold(3'b000, 3'b101, 1'b1, 2);            // phase a into DEAD
      step(3'b000, 3'b101, 1'b1, 1'b0, 1'b0);   // reset mid-DEAD
      hold(3'b000, 3'b101, 1'b1, 4);

      rh = 3'b000; rl = 3'b000; ren = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 2))
                  0: begin rh[i] = 1'b0; rl[i] = 1'b0; end
                  1: begin rh[i] = 1'b1; rl[i] = 1'b0; end
                  default: begin rh[i] = 1'b0; rl[i] = 1'b1; end
               endcase
            end
         end
         if ($urandom_range(0, 31) == 0) ren = ~ren;
         if ($urandom_range(0, 199) == 0) begin
            step(rh | 3'b010, rl | 3'b010, ren, 1'b0, 1'b1);
         end else begin
            step(rh, rl, ren, ($urandom_range(0, 15) == 0), ($urandom_range(0, 499) != 0));
         end
      end
      stim_done = 1;

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d words left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
